// File: rtl/coin_classifier_if.sv
// Coin result handshake bundle.
// Carries the classified coin type with valid/ready flow control.
interface coin_classifier_if;
    logic       coin_valid;
    logic       coin_ready;
    logic [1:0] coin_type;

    modport master (
        output coin_valid,
        output coin_type,
        input  coin_ready
    );

    modport slave (
        input  coin_valid,
        input  coin_type,
        output coin_ready
    );
endinterface

// File: rtl/coin_classifier.sv
// Coin classifier: measures sensor pulse width and classifies coins.
// Optional credit accumulator enabled by macro COIN_CREDIT_EN.
module coin_classifier #(
    parameter int CNT_W       = 8,
    parameter int DIME_MIN    = 2,
    parameter int DIME_MAX    = 4,
    parameter int NICKEL_MIN  = 6,
    parameter int NICKEL_MAX  = 8,
    parameter int QUARTER_MIN = 10,
    parameter int QUARTER_MAX = 12,
    parameter int CREDIT_W    = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               coin_sensor,
    coin_classifier_if.master  bus,
    output logic               coin_reject,
    output logic               busy,
    output logic               overrun
`ifdef COIN_CREDIT_EN
    ,
    input  logic               credit_clr,
    output logic [CREDIT_W-1:0] credit
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEAS,
        S_JAM
    } state_t;

    localparam logic [CNT_W-1:0] L_CMAX = '1;
    localparam logic [CNT_W-1:0] L_DMIN = CNT_W'(DIME_MIN);
    localparam logic [CNT_W-1:0] L_DMAX = CNT_W'(DIME_MAX);
    localparam logic [CNT_W-1:0] L_NMIN = CNT_W'(NICKEL_MIN);
    localparam logic [CNT_W-1:0] L_NMAX = CNT_W'(NICKEL_MAX);
    localparam logic [CNT_W-1:0] L_QMIN = CNT_W'(QUARTER_MIN);
    localparam logic [CNT_W-1:0] L_QMAX = CNT_W'(QUARTER_MAX);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_reject;
    logic             r_valid;
    logic [1:0]       r_type;
    logic             r_overrun;

    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_fall;
    logic             w_hit;
    logic [1:0]       w_new_type;
    logic             w_new;
    logic             w_rej;
    logic             w_hs;

    // Saturating width increment and window match on the current count.
    always_comb begin
        w_cnt_inc  = (r_cnt == L_CMAX) ? r_cnt : r_cnt + 1'b1;
        w_fall     = (r_state == S_MEAS) && !coin_sensor;
        w_new_type = 2'b00;
        if (r_cnt >= L_DMIN && r_cnt <= L_DMAX)
            w_new_type = 2'b01;
        else if (r_cnt >= L_NMIN && r_cnt <= L_NMAX)
            w_new_type = 2'b10;
        else if (r_cnt >= L_QMIN && r_cnt <= L_QMAX)
            w_new_type = 2'b11;
        w_hit = (w_new_type != 2'b00);
        w_new = w_fall && w_hit;
        w_rej = (w_fall && !w_hit) ||
                ((r_state == S_JAM) && !coin_sensor);
        w_hs  = r_valid && bus.coin_ready;
    end

    // Measurement FSM with registered reject pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_reject <= 1'b0;
        end else begin
            r_reject <= w_rej;
            unique case (r_state)
                S_IDLE: begin
                    if (coin_sensor) begin
                        r_state <= S_MEAS;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                S_MEAS: begin
                    if (coin_sensor) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc > L_QMAX)
                            r_state <= S_JAM;
                    end else begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                end
                S_JAM: begin
                    if (coin_sensor) begin
                        r_cnt <= w_cnt_inc;
                    end else begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // One-entry result register; a result that finds it full is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= 1'b0;
            r_type    <= 2'b00;
            r_overrun <= 1'b0;
        end else if (w_new) begin
            if (!r_valid || bus.coin_ready) begin
                r_valid <= 1'b1;
                r_type  <= w_new_type;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (w_hs) begin
            r_valid <= 1'b0;
            r_type  <= 2'b00;
        end
    end

    assign bus.coin_valid = r_valid;
    assign bus.coin_type  = r_type;
    assign coin_reject    = r_reject;
    assign busy           = (r_state != S_IDLE);
    assign overrun        = r_overrun;

`ifdef COIN_CREDIT_EN
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W:0]   w_add;

    // Cents value of the coin being handed over.
    always_comb begin
        w_add = '0;
        unique case (r_type)
            2'b01:   w_add = (CREDIT_W+1)'(10);
            2'b10:   w_add = (CREDIT_W+1)'(5);
            2'b11:   w_add = (CREDIT_W+1)'(25);
            default: w_add = '0;
        endcase
        w_sum = {1'b0, r_credit} + w_add;
    end

    // Saturating credit; clear wins over a same-edge handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_credit <= '0;
        end else if (credit_clr) begin
            r_credit <= '0;
        end else if (w_hs) begin
            if (w_sum[CREDIT_W])
                r_credit <= '1;
            else
                r_credit <= w_sum[CREDIT_W-1:0];
        end
    end

    assign credit = r_credit;
`endif

endmodule

// File: tb/tb_coin_classifier.sv
// Self-checking bench for coin_classifier.
// Expected coin types are queued when a pulse is driven.
module tb_coin_classifier;

    logic clk;
    logic reset_n;
    logic coin_sensor;
    logic coin_reject;
    logic busy;
    logic overrun;
`ifdef COIN_CREDIT_EN
    logic       credit_clr;
    logic [7:0] credit;
    int         exp_credit;
`endif

    coin_classifier_if bus_if ();

    coin_classifier dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .coin_sensor (coin_sensor),
        .bus         (bus_if.master),
        .coin_reject (coin_reject),
        .busy        (busy),
        .overrun     (overrun)
`ifdef COIN_CREDIT_EN
        ,
        .credit_clr  (credit_clr),
        .credit      (credit)
`endif
    );

    int passed = 0;
    int total  = 0;
    int rej_cnt = 0;
    int val_cnt = 0;
    int busy_cnt = 0;
    logic [1:0] exp_q[$];
    logic [1:0] e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        if (coin_reject === 1'b1) rej_cnt++;
        if (bus_if.coin_valid === 1'b1) val_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    // Called right after a falling edge; returns on the edge where
    // the sensor drops, so the next rising edge samples it low.
    task automatic pulse(input int w);
        coin_sensor = 1'b1;
        repeat (w) @(negedge clk);
        coin_sensor = 1'b0;
    endtask

    task automatic pop_exp();
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 2'bxx;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        coin_sensor = 1'b0;
        bus_if.coin_ready = 1'b0;
`ifdef COIN_CREDIT_EN
        credit_clr = 1'b0;
        exp_credit = 0;
`endif
        repeat (2) @(negedge clk);
        total++;
        if ({bus_if.coin_valid, bus_if.coin_type, coin_reject,
             busy, overrun} !== 6'b0)
            $display("FAIL reset_outputs got=%b exp=000000",
                {bus_if.coin_valid, bus_if.coin_type, coin_reject,
                 busy, overrun});
        else passed++;
`ifdef COIN_CREDIT_EN
        total++;
        if (credit !== 8'd0)
            $display("FAIL reset_credit got=%0d exp=0", credit);
        else passed++;
`endif
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_dime_hold();
        bus_if.coin_ready = 1'b0;
        exp_q.push_back(2'b01);
        pulse(3);
        total++;
        if (bus_if.coin_valid !== 1'b0)
            $display("FAIL dime_early got=%b exp=0", bus_if.coin_valid);
        else passed++;
        @(negedge clk);
        pop_exp();
        total++;
        if (bus_if.coin_valid !== 1'b1 || bus_if.coin_type !== e)
            $display("FAIL dime_load got=%b/%b exp=1/%b",
                bus_if.coin_valid, bus_if.coin_type, e);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (bus_if.coin_valid !== 1'b1 || bus_if.coin_type !== e)
            $display("FAIL dime_hold got=%b/%b exp=1/%b",
                bus_if.coin_valid, bus_if.coin_type, e);
        else passed++;
        bus_if.coin_ready = 1'b1;
        @(negedge clk);
        bus_if.coin_ready = 1'b0;
        total++;
        if (bus_if.coin_valid !== 1'b0 || bus_if.coin_type !== 2'b00)
            $display("FAIL dime_clear got=%b/%b exp=0/00",
                bus_if.coin_valid, bus_if.coin_type);
        else passed++;
    endtask

    task automatic test_ready_tied();
        int widths[2] = '{7, 11};
        logic [1:0] types[2] = '{2'b10, 2'b11};
        bus_if.coin_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(types[i]);
            pulse(widths[i]);
            @(negedge clk);
            pop_exp();
            total++;
            if (bus_if.coin_valid !== 1'b1 || bus_if.coin_type !== e)
                $display("FAIL tied_load w=%0d got=%b/%b exp=1/%b",
                    widths[i], bus_if.coin_valid, bus_if.coin_type, e);
            else passed++;
            @(negedge clk);
            total++;
            if (bus_if.coin_valid !== 1'b0)
                $display("FAIL tied_one_cycle w=%0d got=%b exp=0",
                    widths[i], bus_if.coin_valid);
            else passed++;
        end
        total++;
        if (overrun !== 1'b0)
            $display("FAIL tied_overrun got=%b exp=0", overrun);
        else passed++;
        bus_if.coin_ready = 1'b0;
    endtask

    task automatic test_reject();
        int widths[4] = '{1, 5, 9, 20};
        int r0;
        int v0;
        bus_if.coin_ready = 1'b0;
        v0 = val_cnt;
        for (int i = 0; i < 4; i++) begin
            r0 = rej_cnt;
            busy_cnt = 0;
            pulse(widths[i]);
            repeat (3) @(negedge clk);
            total++;
            if (rej_cnt - r0 !== 1)
                $display("FAIL reject_pulse w=%0d got=%0d exp=1",
                    widths[i], rej_cnt - r0);
            else passed++;
            total++;
            if (busy_cnt !== widths[i])
                $display("FAIL reject_busy w=%0d got=%0d exp=%0d",
                    widths[i], busy_cnt, widths[i]);
            else passed++;
        end
        total++;
        if (val_cnt - v0 !== 0 || overrun !== 1'b0)
            $display("FAIL reject_no_valid got=%0d/%b exp=0/0",
                val_cnt - v0, overrun);
        else passed++;
    endtask

    task automatic test_overrun();
        bus_if.coin_ready = 1'b0;
        exp_q.push_back(2'b01);
        pulse(3);
        @(negedge clk);
        pop_exp();
        total++;
        if (bus_if.coin_type !== e || overrun !== 1'b0)
            $display("FAIL ovr_first got=%b/%b exp=%b/0",
                bus_if.coin_type, overrun, e);
        else passed++;
        pulse(11);
        repeat (2) @(negedge clk);
        total++;
        if (bus_if.coin_valid !== 1'b1 || bus_if.coin_type !== e ||
            overrun !== 1'b1)
            $display("FAIL ovr_drop got=%b/%b/%b exp=1/%b/1",
                bus_if.coin_valid, bus_if.coin_type, overrun, e);
        else passed++;
        exp_q.push_back(2'b10);
        pulse(7);
        bus_if.coin_ready = 1'b1;
        @(negedge clk);
        pop_exp();
        total++;
        if (bus_if.coin_valid !== 1'b1 || bus_if.coin_type !== e)
            $display("FAIL ovr_same_edge got=%b/%b exp=1/%b",
                bus_if.coin_valid, bus_if.coin_type, e);
        else passed++;
        @(negedge clk);
        bus_if.coin_ready = 1'b0;
        total++;
        if (bus_if.coin_valid !== 1'b0 || overrun !== 1'b1)
            $display("FAIL ovr_sticky got=%b/%b exp=0/1",
                bus_if.coin_valid, overrun);
        else passed++;
    endtask

    task automatic test_reset_mid();
        bus_if.coin_ready = 1'b0;
        exp_q.push_back(2'b01);
        pulse(3);
        @(negedge clk);
        pop_exp();
        total++;
        if (bus_if.coin_valid !== 1'b1 || bus_if.coin_type !== e)
            $display("FAIL mid_pre got=%b/%b exp=1/%b",
                bus_if.coin_valid, bus_if.coin_type, e);
        else passed++;
        coin_sensor = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({bus_if.coin_valid, bus_if.coin_type, coin_reject,
             busy, overrun} !== 6'b0)
            $display("FAIL mid_async got=%b exp=000000",
                {bus_if.coin_valid, bus_if.coin_type, coin_reject,
                 busy, overrun});
        else passed++;
`ifdef COIN_CREDIT_EN
        exp_credit = 0;
`endif
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(2'b01);
        repeat (3) @(negedge clk);
        coin_sensor = 1'b0;
        @(negedge clk);
        pop_exp();
        total++;
        if (bus_if.coin_valid !== 1'b1 || bus_if.coin_type !== e)
            $display("FAIL mid_afresh got=%b/%b exp=1/%b",
                bus_if.coin_valid, bus_if.coin_type, e);
        else passed++;
        bus_if.coin_ready = 1'b1;
        @(negedge clk);
        bus_if.coin_ready = 1'b0;
`ifdef COIN_CREDIT_EN
        exp_credit += 10;
`endif
    endtask

`ifdef COIN_CREDIT_EN
    task automatic test_credit();
        int widths[3] = '{3, 11, 11};
        bus_if.coin_ready = 1'b0;
        credit_clr = 1'b1;
        @(negedge clk);
        credit_clr = 1'b0;
        exp_credit = 0;
        bus_if.coin_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse(widths[i]);
            repeat (2) @(negedge clk);
            exp_credit += (widths[i] == 3) ? 10 : 25;
        end
        total++;
        if (credit !== 8'(exp_credit) || exp_credit != 60)
            $display("FAIL credit_sum got=%0d exp=60", credit);
        else passed++;
        bus_if.coin_ready = 1'b0;
        pulse(7);
        @(negedge clk);
        bus_if.coin_ready = 1'b1;
        credit_clr = 1'b1;
        @(negedge clk);
        credit_clr = 1'b0;
        bus_if.coin_ready = 1'b0;
        total++;
        if (credit !== 8'd0 || bus_if.coin_valid !== 1'b0)
            $display("FAIL credit_clr got=%0d/%b exp=0/0",
                credit, bus_if.coin_valid);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_dime_hold();
        test_ready_tied();
        test_reject();
        test_overrun();
        test_reset_mid();
`ifdef COIN_CREDIT_EN
        test_credit();
`endif
        total++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
